ysyx_23060332_lsu: RTL and testbench

Load/store unit: the initiator side of the data-memory interface whose responder is the DPI-backed memory model. Accepts one load or store from EXU per valid/ready handshake. Drives a word-aligned, byte-masked request with a request/response handshake, then returns the aligned and sign/zero-extended load result, or a store acknowledgement, to WBU. One transaction is in flight at a time; misaligned accesses are trapped locally and never reach memory.

---
 rtl/ysyx_23060332_lsu_pkg.sv | 44 ++++
 rtl/ysyx_23060332_lsu_fmt.sv | 45 ++++
 rtl/ysyx_23060332_lsu.sv | 140 ++++++++++++++
 tb/tb_ysyx_23060332_lsu.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060332_lsu_pkg.sv
// Shared types for the load/store unit: FSM states, funct3 codes and
// access-size helpers used by both the controller and the formatter.
package ysyx_23060332_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Unused funct3 codes (011, 110, 111) fall into the word bucket.
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3_size(f3))
      SZ_H:    return lo[0];
      SZ_W:    return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060332_lsu_fmt.sv
// Combinational byte-lane formatter: store mask/data placement and
// load extraction with sign or zero extension.
module ysyx_23060332_lsu_fmt
  import ysyx_23060332_lsu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [2:0]    i_funct3,
  input  logic [1:0]    i_sh,
  input  logic [DW-1:0] i_wdata,
  input  logic [DW-1:0] i_rdata,
  output logic [3:0]    o_wmask,
  output logic [DW-1:0] o_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [3:0]    w_mask_base;
  logic [DW-1:0] w_word;

  // Store lane placement.
  always_comb begin
    w_mask_base = 4'b0000;
    case (f3_size(i_funct3))
      SZ_B:    w_mask_base = 4'b0001;
      SZ_H:    w_mask_base = 4'b0011;
      default: w_mask_base = 4'b1111;
    endcase
    o_wmask = w_mask_base << i_sh;
    o_wdata = i_wdata << {i_sh, 3'b000};
  end

  // Load extract and extend.
  always_comb begin
    w_word  = i_rdata >> {i_sh, 3'b000};
    o_rdata = w_word;
    case (i_funct3)
      F3_LB:   o_rdata = {{(DW-8){w_word[7]}}, w_word[7:0]};
      F3_LH:   o_rdata = {{(DW-16){w_word[15]}}, w_word[15:0]};
      F3_LBU:  o_rdata = {{(DW-8){1'b0}}, w_word[7:0]};
      F3_LHU:  o_rdata = {{(DW-16){1'b0}}, w_word[15:0]};
      default: o_rdata = w_word;
    endcase
  end

endmodule

// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit: one transaction at a time from EXU to data memory and
// back to WBU; misaligned accesses are trapped without touching memory.
module ysyx_23060332_lsu
  import ysyx_23060332_lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_wen,
  input  logic [2:0]    in_funct3,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_wdata,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [7:0]    mem_wmask,
  input  logic          mem_rsp_valid,
  output logic          mem_rsp_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_rdata,
  output logic          out_err
);

  lsu_state_e    r_state;
  lsu_state_e    w_state_nxt;
  logic          r_wen;
  logic [2:0]    r_funct3;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_err;
  logic          w_in_req;
  logic          w_store_req;
  logic [3:0]    w_fmt_wmask;
  logic [DW-1:0] w_fmt_wdata;
  logic [DW-1:0] w_fmt_rdata;

  ysyx_23060332_lsu_fmt #(.DW(DW)) u_fmt (
    .i_funct3 (r_funct3),
    .i_sh     (r_addr[1:0]),
    .i_wdata  (r_wdata),
    .i_rdata  (mem_rdata),
    .o_wmask  (w_fmt_wmask),
    .o_wdata  (w_fmt_wdata),
    .o_rdata  (w_fmt_rdata)
  );

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = is_misaligned(in_funct3, in_addr[1:0]) ? S_DONE : S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_req_ready) w_state_nxt = S_WAIT;
        else               w_state_nxt = S_REQ;
      end
      S_WAIT: begin
        if (mem_rsp_valid) w_state_nxt = S_DONE;
        else               w_state_nxt = S_WAIT;
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
        else           w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Request latch and result capture; the result is cleared once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen    <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= {AW{1'b0}};
      r_wdata  <= {DW{1'b0}};
      r_rdata  <= {DW{1'b0}};
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_wen    <= in_wen;
            r_funct3 <= in_funct3;
            r_addr   <= in_addr;
            r_wdata  <= in_wdata;
            r_rdata  <= {DW{1'b0}};
            r_err    <= is_misaligned(in_funct3, in_addr[1:0]);
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) r_rdata <= r_wen ? {DW{1'b0}} : w_fmt_rdata;
        end
        S_DONE: begin
          if (out_ready) begin
            r_rdata <= {DW{1'b0}};
            r_err   <= 1'b0;
          end
        end
        default: begin
          r_rdata <= {DW{1'b0}};
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign w_in_req      = (r_state == S_REQ);
  assign w_store_req   = w_in_req & r_wen;
  assign in_ready      = (r_state == S_IDLE);
  assign mem_req_valid = w_in_req;
  assign mem_wen       = w_store_req;
  assign mem_addr      = {r_addr[AW-1:2], 2'b00};
  assign mem_wdata     = w_store_req ? w_fmt_wdata : {DW{1'b0}};
  assign mem_wmask     = {4'b0000, (w_store_req ? w_fmt_wmask : 4'b0000)};
  assign mem_rsp_ready = (r_state == S_WAIT);
  assign out_valid     = (r_state == S_DONE);
  assign out_rdata     = r_rdata;
  assign out_err       = r_err;

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Self-checking bench for ysyx_23060332_lsu: directed cases plus randomized
// transactions checked against an arithmetic reference of the access rules.
module tb_ysyx_23060332_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wen;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid, mem_rsp_ready;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;

  int vectors     = 0;
  int miscompares = 0;
  int req_hs      = 0;
  int out_hs      = 0;

  ysyx_23060332_lsu #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_ready(mem_rsp_ready), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Handshake counters for request and output beats.
  always @(posedge clk) begin
    if (!rst && mem_req_valid && mem_req_ready) req_hs <= req_hs + 1;
    if (!rst && out_valid && out_ready)         out_hs <= out_hs + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00)      return 1;
    else if (f3[1:0] == 2'b01) return 2;
    else                       return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] sh,
                                           input logic [31:0] word);
    longint v, b;
    v = longint'(word) >> (8 * sh);
    case (f3)
      3'd0:    begin b = v % 256;   if (b >= 128)   b -= 256;   end
      3'd1:    begin b = v % 65536; if (b >= 32768) b -= 65536; end
      3'd4:    b = v % 256;
      3'd5:    b = v % 65536;
      default: b = v;
    endcase
    return b[31:0];
  endfunction

  task automatic run_txn(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int req_st, input int rsp_st, input int out_st);
    int nb, req0, out0;
    logic mis;
    logic [31:0] exp_mask, exp_wd, exp_rd, exp_addr;
    nb       = size_bytes(f3);
    mis      = (addr % nb) != 0;
    exp_addr = addr - (addr % 4);
    exp_mask = ((32'd1 << nb) - 32'd1) << addr[1:0];
    exp_wd   = wdata << (8 * addr[1:0]);
    exp_rd   = mis ? 32'd0 : (wen ? 32'd0 : ref_load(f3, addr[1:0], rdata));
    req0 = req_hs;
    out0 = out_hs;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    in_valid = 1'b1; in_wen = wen; in_funct3 = f3; in_addr = addr; in_wdata = wdata;
    @(negedge clk);
    in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom; in_wen = ~wen;
    if (mis) begin
      chk("mis_req_valid", mem_req_valid, 0);
    end else begin
      for (int k = 0; k <= req_st; k++) begin
        chk("req_valid", mem_req_valid, 1);
        chk("req_in_ready", in_ready, 0);
        chk("req_addr", mem_addr, exp_addr);
        chk("req_wen", mem_wen, wen);
        chk("req_wmask", mem_wmask, wen ? exp_mask : 32'd0);
        chk("req_wdata", mem_wdata, wen ? exp_wd : 32'd0);
        if (k == req_st) mem_req_ready = 1'b1;
        @(negedge clk);
      end
      mem_req_ready = 1'b0;
      for (int k = 0; k <= rsp_st; k++) begin
        chk("wait_req_valid", mem_req_valid, 0);
        chk("wait_rsp_ready", mem_rsp_ready, 1);
        chk("wait_out_valid", out_valid, 0);
        if (k == rsp_st) begin mem_rsp_valid = 1'b1; mem_rdata = rdata; end
        else mem_rdata = $urandom;
        @(negedge clk);
      end
    end
    for (int k = 0; k <= out_st; k++) begin
      chk("done_out_valid", out_valid, 1);
      chk("done_out_err", out_err, mis);
      chk("done_out_rdata", out_rdata, exp_rd);
      // Stray responses during DONE must not disturb the held result.
      mem_rsp_valid = 1'($urandom_range(1, 0));
      mem_rdata     = $urandom;
      if (k == out_st) out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0; mem_rsp_valid = 1'b0;
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("req_count", 32'(req_hs - req0), mis ? 32'd0 : 32'd1);
    chk("out_count", 32'(out_hs - out0), 32'd1);
  endtask

  initial begin
    int out0;
    logic [2:0] f3;
    rst = 1'b1; in_valid = 1'b0; in_wen = 1'b0; in_funct3 = 3'd0;
    in_addr = 32'd0; in_wdata = 32'd0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rdata = 32'd0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wmask", mem_wmask, 0);
    chk("rst_rsp_ready", mem_rsp_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_rdata", out_rdata, 0);
    chk("rst_out_err", out_err, 0);
    rst = 1'b0;

    run_txn(1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
    run_txn(1'b1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 32'h0, 0, 0, 0);
    run_txn(1'b1, 3'b001, 32'h8000_0002, 32'h0000_1234, 32'h0, 1, 0, 0);
    run_txn(1'b0, 3'b000, 32'h8000_0002, 32'h0, 32'h12F0_3456, 0, 0, 0);
    run_txn(1'b0, 3'b100, 32'h8000_0002, 32'h0, 32'h12F0_3456, 0, 0, 0);
    run_txn(1'b0, 3'b001, 32'h8000_0001, 32'h0, 32'h12F0_3456, 0, 0, 1);
    run_txn(1'b0, 3'b010, 32'h8000_0008, 32'h0, 32'h8765_4321, 4, 1, 2);
    run_txn(1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h8001_7FFF, 0, 2, 0);
    run_txn(1'b1, 3'b010, 32'h8000_0006, 32'h1111_2222, 32'h0, 0, 0, 0);

    // Reset while waiting for the response; a late response must be ignored.
    out0 = out_hs;
    @(negedge clk);
    in_valid = 1'b1; in_wen = 1'b0; in_funct3 = 3'b010; in_addr = 32'h8000_0010;
    @(negedge clk);
    in_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rstw_rsp_ready", mem_rsp_ready, 1);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_in_ready", in_ready, 1);
    chk("rstw_out_valid", out_valid, 0);
    chk("rstw_rsp_ready2", mem_rsp_ready, 0);
    mem_rsp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("rstw_late_out_valid", out_valid, 0);
    chk("rstw_late_in_ready", in_ready, 1);
    chk("rstw_out_count", 32'(out_hs - out0), 32'd0);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(7, 0));
      if (i % 2 == 0)
        run_txn(1'b1, 3'($urandom_range(2, 0)), $urandom, $urandom, 32'h0,
                $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0));
      else
        run_txn(1'b0, f3, $urandom, 32'h0, $urandom,
                $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
